// File: rtl/bus_arb2.sv
// bus_arb2: two-master round-robin arbiter onto one shared request/ack bus,
// with a per-transfer wait timeout that returns ack+err to the granted master.
module bus_arb2 #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    // master 0 (CPU)
    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic [23:2] m0_addr,
    input  logic [31:0] m0_dout,
    output logic [31:0] m0_din,
    output logic        m0_ack,
    output logic        m0_err,
    // master 1 (DMA/aux)
    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic [23:2] m1_addr,
    input  logic [31:0] m1_dout,
    output logic [31:0] m1_din,
    output logic        m1_ack,
    output logic        m1_err,
    // shared bus
    output logic        bus_stb,
    output logic        bus_we,
    output logic [23:2] bus_addr,
    output logic [31:0] bus_dout,
    input  logic [31:0] bus_din,
    input  logic        bus_ack,
    output logic [1:0]  grant
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_m1_q, last_m1_d;

    logic               act_stb_c;
    logic               to_hit_c;
    logic               xfer_ack_c;
    logic               xfer_to_c;

    // Read data is shared by both masters; only ack tells them apart.
    assign m0_din = bus_din;
    assign m1_din = bus_din;

    // Granted master's strobe and the end-of-transfer conditions.
    always_comb begin
        act_stb_c = 1'b0;
        case (state_q)
            G0:      act_stb_c = m0_stb;
            G1:      act_stb_c = m1_stb;
            default: act_stb_c = 1'b0;
        endcase
        to_hit_c   = (cnt_q == CNT_W'(TIMEOUT - 1));
        xfer_ack_c = act_stb_c & bus_ack;
        xfer_to_c  = act_stb_c & ~bus_ack & to_hit_c;
    end

    // State, wait counter and last-served flag; reset leaves m0 winning the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_m1_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_m1_q <= last_m1_d;
        end
    end

    // Next-state: round-robin on ties, leave a grant on ack, timeout or dropped strobe.
    always_comb begin
        state_d   = state_q;
        last_m1_d = last_m1_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (m0_stb && m1_stb) begin
                    if (last_m1_q) begin
                        state_d   = G0;
                        last_m1_d = 1'b0;
                    end else begin
                        state_d   = G1;
                        last_m1_d = 1'b1;
                    end
                end else if (m0_stb) begin
                    state_d   = G0;
                    last_m1_d = 1'b0;
                end else if (m1_stb) begin
                    state_d   = G1;
                    last_m1_d = 1'b1;
                end
            end
            G0, G1: begin
                if (!bus_ack) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (!act_stb_c || bus_ack || to_hit_c) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output mux; everything is held at zero while reset is asserted.
    always_comb begin
        bus_stb  = 1'b0;
        bus_we   = 1'b0;
        bus_addr = '0;
        bus_dout = '0;
        m0_ack   = 1'b0;
        m0_err   = 1'b0;
        m1_ack   = 1'b0;
        m1_err   = 1'b0;
        grant    = 2'b00;
        if (!rst) begin
            case (state_q)
                G0: begin
                    grant    = 2'b01;
                    bus_stb  = m0_stb;
                    bus_we   = m0_we;
                    bus_addr = m0_addr;
                    bus_dout = m0_dout;
                    m0_ack   = xfer_ack_c | xfer_to_c;
                    m0_err   = xfer_to_c;
                end
                G1: begin
                    grant    = 2'b10;
                    bus_stb  = m1_stb;
                    bus_we   = m1_we;
                    bus_addr = m1_addr;
                    bus_dout = m1_dout;
                    m1_ack   = xfer_ack_c | xfer_to_c;
                    m1_err   = xfer_to_c;
                end
                default: begin
                    grant = 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arb2.sv
// tb_bus_arb2: directed vector table plus hand sequences for ties, timeout,
// ack/timeout collision and reset mid-transfer.
module tb_bus_arb2;

    typedef struct packed {
        logic [1:0]  grant;
        logic        bstb;
        logic        bwe;
        logic [21:0] baddr;
        logic [31:0] bdout;
        logic        m0a;
        logic        m0e;
        logic        m1a;
        logic        m1e;
    } out_t;

    typedef struct packed {
        logic        rst;
        logic        m0s;
        logic        m0w;
        logic [21:0] m0a;
        logic [31:0] m0d;
        logic        m1s;
        logic        m1w;
        logic [21:0] m1a;
        logic [31:0] m1d;
        logic [31:0] bdin;
        logic        back;
        out_t        e;
    } vec_t;

    logic        clk, rst;
    logic        m0_stb, m0_we, m0_ack, m0_err;
    logic        m1_stb, m1_we, m1_ack, m1_err;
    logic [21:0] m0_addr, m1_addr, bus_addr;
    logic [31:0] m0_dout, m1_dout, m0_din, m1_din, bus_dout, bus_din;
    logic        bus_stb, bus_we, bus_ack;
    logic [1:0]  grant;

    int n_cmp = 0;
    int n_bad = 0;

    bus_arb2 #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr), .m0_dout(m0_dout),
        .m0_din(m0_din), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr), .m1_dout(m1_dout),
        .m1_din(m1_din), .m1_ack(m1_ack), .m1_err(m1_err),
        .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr), .bus_dout(bus_dout),
        .bus_din(bus_din), .bus_ack(bus_ack), .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input out_t e);
        chk({tag, ".grant"},   32'(grant),    32'(e.grant));
        chk({tag, ".bus_stb"}, 32'(bus_stb),  32'(e.bstb));
        chk({tag, ".bus_we"},  32'(bus_we),   32'(e.bwe));
        chk({tag, ".bus_addr"},32'(bus_addr), 32'(e.baddr));
        chk({tag, ".bus_dout"},bus_dout,      e.bdout);
        chk({tag, ".m0_ack"},  32'(m0_ack),   32'(e.m0a));
        chk({tag, ".m0_err"},  32'(m0_err),   32'(e.m0e));
        chk({tag, ".m1_ack"},  32'(m1_ack),   32'(e.m1a));
        chk({tag, ".m1_err"},  32'(m1_err),   32'(e.m1e));
        chk({tag, ".m0_din"},  m0_din,        bus_din);
        chk({tag, ".m1_din"},  m1_din,        bus_din);
    endtask

    function automatic out_t o(input logic [1:0] g, input logic bs, input logic bw,
                               input logic [21:0] ba, input logic [31:0] bd,
                               input logic a0, input logic e0, input logic a1, input logic e1);
        out_t r;
        r.grant = g; r.bstb = bs; r.bwe = bw; r.baddr = ba; r.bdout = bd;
        r.m0a = a0; r.m0e = e0; r.m1a = a1; r.m1e = e1;
        return r;
    endfunction

    function automatic vec_t v(input logic r, input logic s0, input logic w0,
                               input logic [21:0] a0, input logic [31:0] d0,
                               input logic s1, input logic w1,
                               input logic [21:0] a1, input logic [31:0] d1,
                               input logic [31:0] bdin, input logic back, input out_t e);
        vec_t x;
        x.rst = r; x.m0s = s0; x.m0w = w0; x.m0a = a0; x.m0d = d0;
        x.m1s = s1; x.m1w = w1; x.m1a = a1; x.m1d = d1;
        x.bdin = bdin; x.back = back; x.e = e;
        return x;
    endfunction

    task automatic drive(input vec_t x);
        rst = x.rst;
        m0_stb = x.m0s; m0_we = x.m0w; m0_addr = x.m0a; m0_dout = x.m0d;
        m1_stb = x.m1s; m1_we = x.m1w; m1_addr = x.m1a; m1_dout = x.m1d;
        bus_din = x.bdin; bus_ack = x.back;
    endtask

    task automatic quiet();
        m0_stb = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_dout = '0;
        m1_stb = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_dout = '0;
        bus_ack = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t       tbl [13];
    logic [1:0] tie_g [13];
    out_t       oz;

    initial begin
        oz = '0;
        tbl[0]  = v(1, 0,0,22'h0,32'h0,          0,0,22'h0,32'h0,          32'h11111111, 0, oz);
        tbl[1]  = v(1, 1,0,22'h100,32'h0,        0,0,22'h0,32'h0,          32'h11111111, 0, oz);
        tbl[2]  = v(0, 1,0,22'h100,32'h0,        0,0,22'h0,32'h0,          32'h0, 0, oz);
        tbl[3]  = v(0, 1,0,22'h100,32'h0,        0,0,22'h0,32'h0,          32'h0, 0,
                    o(2'b01,1,0,22'h100,32'h0, 0,0,0,0));
        tbl[4]  = v(0, 1,0,22'h100,32'h0,        0,0,22'h0,32'h0,          32'h0, 0,
                    o(2'b01,1,0,22'h100,32'h0, 0,0,0,0));
        tbl[5]  = v(0, 1,0,22'h100,32'h0,        0,0,22'h0,32'h0,          32'h0, 0,
                    o(2'b01,1,0,22'h100,32'h0, 0,0,0,0));
        tbl[6]  = v(0, 1,0,22'h100,32'h0,        0,0,22'h0,32'h0,          32'hDEADBEEF, 1,
                    o(2'b01,1,0,22'h100,32'h0, 1,0,0,0));
        tbl[7]  = v(0, 0,0,22'h0,32'h0,          0,0,22'h0,32'h0,          32'h0, 0, oz);
        tbl[8]  = v(0, 0,0,22'h0,32'h0,          1,1,22'h2A5A5,32'hCAFEF00D, 32'h0, 0, oz);
        tbl[9]  = v(0, 0,0,22'h0,32'h0,          1,1,22'h2A5A5,32'hCAFEF00D, 32'h0, 0,
                    o(2'b10,1,1,22'h2A5A5,32'hCAFEF00D, 0,0,0,0));
        tbl[10] = v(0, 0,0,22'h0,32'h0,          0,0,22'h0,32'h0,          32'h0, 0,
                    o(2'b10,0,0,22'h0,32'h0, 0,0,0,0));
        tbl[11] = v(0, 0,0,22'h0,32'h0,          0,0,22'h0,32'h0,          32'h5A5A5A5A, 1, oz);
        tbl[12] = v(0, 0,0,22'h0,32'h0,          0,0,22'h0,32'h0,          32'h0, 0, oz);

        // Table: reset, single read, dropped strobe, stray ack in idle
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i]);
            #4;
            check_out($sformatf("row%0d", i), tbl[i].e);
            next_cycle();
        end

        // Tie after reset: both masters do 3 back-to-back writes, slave acks at once
        rst = 1'b1; quiet(); bus_din = 32'h0;
        next_cycle();
        rst = 1'b0;
        tie_g = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0};
        begin
            int i0, i1;
            i0 = 0; i1 = 0;
            for (int c = 0; c < 13; c++) begin
                m0_stb = (i0 < 3); m0_we = (i0 < 3);
                m0_addr = 22'h100 + 22'(i0); m0_dout = 32'hA0000000 + 32'(i0);
                m1_stb = (i1 < 3); m1_we = (i1 < 3);
                m1_addr = 22'h200 + 22'(i1); m1_dout = 32'hB0000000 + 32'(i1);
                bus_ack = 1'b0;
                #1;
                bus_ack = bus_stb;
                #3;
                chk($sformatf("tie%0d.grant", c), 32'(grant), 32'(tie_g[c]));
                chk($sformatf("tie%0d.bus_stb", c), 32'(bus_stb), 32'(tie_g[c] != 2'd0));
                chk($sformatf("tie%0d.err", c), 32'({m0_err, m1_err}), 32'(0));
                if (tie_g[c] == 2'd1) begin
                    chk($sformatf("tie%0d.addr0", c), 32'(bus_addr), 32'(22'h100 + 22'(i0)));
                    chk($sformatf("tie%0d.dout0", c), bus_dout, 32'hA0000000 + 32'(i0));
                    chk($sformatf("tie%0d.acks", c), 32'({m0_ack, m1_ack}), 32'(2'b10));
                    i0++;
                end else if (tie_g[c] == 2'd2) begin
                    chk($sformatf("tie%0d.addr1", c), 32'(bus_addr), 32'(22'h200 + 22'(i1)));
                    chk($sformatf("tie%0d.dout1", c), bus_dout, 32'hB0000000 + 32'(i1));
                    chk($sformatf("tie%0d.acks", c), 32'({m0_ack, m1_ack}), 32'(2'b01));
                    i1++;
                end else begin
                    chk($sformatf("tie%0d.acks", c), 32'({m0_ack, m1_ack}), 32'(0));
                end
                next_cycle();
            end
        end

        // Timeout: m1 write never acked, ack+err on the 8th G1 cycle
        quiet();
        m1_stb = 1'b1; m1_we = 1'b1; m1_addr = 22'h3FFFF; m1_dout = 32'h12345678;
        #4;
        chk("to0.grant", 32'(grant), 32'(0));
        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            #4;
            chk($sformatf("to%0d.grant", k), 32'(grant), 32'(2'b10));
            chk($sformatf("to%0d.bus_stb", k), 32'(bus_stb), 32'(1));
            chk($sformatf("to%0d.m1_ack", k), 32'(m1_ack), 32'(k == 8));
            chk($sformatf("to%0d.m1_err", k), 32'(m1_err), 32'(k == 8));
            chk($sformatf("to%0d.m0_ack", k), 32'(m0_ack), 32'(0));
        end
        next_cycle();
        quiet();
        #4;
        check_out("to9", oz);

        // Collision: bus_ack on the 8th G0 cycle wins over the timeout
        next_cycle();
        m0_stb = 1'b1; m0_we = 1'b0; m0_addr = 22'h00ABC;
        #4;
        chk("col0.grant", 32'(grant), 32'(0));
        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            bus_ack = (k == 8);
            bus_din = 32'hC0DE0000 + 32'(k);
            #4;
            chk($sformatf("col%0d.grant", k), 32'(grant), 32'(2'b01));
            chk($sformatf("col%0d.m0_ack", k), 32'(m0_ack), 32'(k == 8));
            chk($sformatf("col%0d.m0_err", k), 32'(m0_err), 32'(0));
            chk($sformatf("col%0d.m1_ack", k), 32'(m1_ack), 32'(0));
        end
        next_cycle();
        quiet();
        #4;
        check_out("col9", oz);

        // Reset mid-transfer, with the slave's ack arriving one cycle late
        next_cycle();
        m0_stb = 1'b1; m0_we = 1'b1; m0_addr = 22'h00055; m0_dout = 32'h0F0F0F0F;
        #4;
        check_out("rm0", oz);
        next_cycle();
        #4;
        check_out("rm1", o(2'b01,1,1,22'h00055,32'h0F0F0F0F, 0,0,0,0));
        next_cycle();
        rst = 1'b1;
        #4;
        check_out("rm2", oz);
        next_cycle();
        rst = 1'b0; quiet(); bus_ack = 1'b1;
        #4;
        check_out("rm3", oz);
        next_cycle();
        bus_ack = 1'b0;
        m0_stb = 1'b1; m0_we = 1'b0; m0_addr = 22'h00066;
        #4;
        check_out("rm4", oz);
        next_cycle();
        bus_ack = 1'b1; bus_din = 32'h600DF00D;
        #4;
        check_out("rm5", o(2'b01,1,0,22'h00066,32'h0, 1,0,0,0));
        next_cycle();
        quiet();
        #4;
        check_out("rm6", oz);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_arb2.md
BUS_ARB2 -- requirements
Module: bus_arb2

Interface
REQ-001 The block SHALL provide parameter TIMEOUT, default 255, meaning the maximum number of cycles a granted transfer may wait for bus_ack (valid range 2..65535).
REQ-002 The block SHALL provide port clk, input, 1, the system clock.
REQ-003 The block SHALL provide port rst, input, 1, the system reset (synchronous, active-high).
REQ-004 The block SHALL provide m0_stb, m0_we, input, 1 each, master 0 (CPU) strobe and write enable.
REQ-005 The block SHALL provide m0_addr, input, [23:2], the master 0 word address.
REQ-006 The block SHALL provide m0_dout, input, 32, the master 0 write data.
REQ-007 The block SHALL provide m0_din, output, 32, the master 0 read data.
REQ-008 The block SHALL provide m0_ack and m0_err, output, 1 each, the master 0 acknowledge and timeout error.
REQ-009 The block SHALL provide m1_stb, m1_we, m1_addr[23:2], m1_dout[31:0], m1_din[31:0], m1_ack and m1_err, with identical meanings for master 1 (DMA/aux).
REQ-010 The block SHALL provide bus_stb, bus_we, output, 1 each, the shared bus strobe and write enable.
REQ-011 The block SHALL provide bus_addr, output, [23:2], the shared bus word address.
REQ-012 The block SHALL provide bus_dout, output, 32, the shared bus write data.
REQ-013 The block SHALL provide bus_din, input, 32, the shared bus read data.
REQ-014 The block SHALL provide bus_ack, input, 1, the shared bus acknowledge.
REQ-015 The block SHALL provide grant, output, 2, the current grant status: 00 idle, 01 m0, 10 m1.

Function
REQ-016 The bus protocol SHALL be as follows: a master holds stb, we, addr and dout stable until it samples ack high; ack is a one-cycle pulse that ends the transfer.
REQ-017 The FSM SHALL have states IDLE, G0 and G1, and grant SHALL equal 00, 01 and 10 respectively.
REQ-018 From IDLE, with only one master's stb high, the FSM SHALL enter that master's G state at the next edge.
REQ-019 From IDLE, with both stb high, the FSM SHALL grant the master not served last (round-robin); the last-served flag SHALL update on grant entry.
REQ-020 The bus_stb output SHALL be 1 only in G0/G1 while the granted master's stb is 1; in IDLE, bus_stb SHALL be 0. Request-to-bus_stb latency SHALL be exactly 1 cycle.
REQ-021 bus_we, bus_addr and bus_dout SHALL be muxed combinationally from the granted master; in IDLE they SHALL be 0.
REQ-022 bus_din SHALL be broadcast to both m0_din and m1_din.
REQ-023 mN_ack SHALL equal bus_ack gated by state GN; the non-granted master SHALL never see ack or err.
REQ-024 On bus_ack in a G state, the FSM SHALL return to IDLE; at least one IDLE cycle SHALL separate consecutive grants.
REQ-025 If the granted master drops stb before ack, the FSM SHALL return to IDLE at the next edge with no ack or err; a later bus_ack in IDLE SHALL be ignored.
REQ-026 A 16-bit wait counter SHALL clear on G entry and increment each G cycle without bus_ack.
REQ-027 On the G cycle where the counter equals TIMEOUT-1 and bus_ack=0, the block SHALL pulse mN_ack=1 and mN_err=1 for that cycle, and the FSM SHALL then return to IDLE.
REQ-028 If bus_ack and timeout coincide, bus_ack SHALL win: ack=1 and err=0.
REQ-029 mN_err SHALL never be 1 without mN_ack=1 in the same cycle.

Reset
REQ-030 While rst=1 at a clock edge, the FSM SHALL go to IDLE, the wait counter SHALL clear, and last-served SHALL be set to m1, so m0 wins the first tie.
REQ-031 During and after reset, all outputs SHALL be 0 (bus_stb, bus_we, bus_addr, bus_dout, mN_ack, mN_err, grant); the mN_din outputs SHALL follow bus_din.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer, and any bus_ack arriving after reset SHALL be dropped.

Verification
REQ-033 Bench scenario, single read: m0 read at addr 0x000100, slave acks 3 cycles after bus_stb with bus_din=0xDEADBEEF -> bus_stb rises 1 cycle after m0_stb; m0_ack=1 with m0_din=0xDEADBEEF; m1_ack stays 0.
REQ-034 Bench scenario, tie after reset: m0_stb and m1_stb both asserted in the same cycle, each doing 3 back-to-back writes -> grant sequence 01,00,10,00,01,00,10,...; each master's writes appear on the bus in order.
REQ-035 Bench scenario, timeout: TIMEOUT=8, m1 write, slave never acks -> m1_ack=1 and m1_err=1 on the 8th G1 cycle; bus_stb=0 and grant=00 the next cycle.
REQ-036 Bench scenario, ack/timeout collision: TIMEOUT=8, bus_ack on the 8th G0 cycle -> m0_ack=1 and m0_err=0.
REQ-037 Bench scenario, reset mid-transfer: rst pulsed during G0 before ack, with bus_ack arriving 1 cycle later -> all outputs 0; no mN_ack seen; the next m0 request is granted normally.
